// File: rtl/sram_arbiter2.sv
// Two-master arbiter in front of a single-port synchronous SRAM (1-cycle read latency).
// Round-robin on ties, per-master lock for atomic sequences, lock timeout against a hung owner.
module sram_arbiter2 #(
    parameter int LEN_ADDR     = 64,
    parameter int LEN_DATA     = 64,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_ADDR-1:0]   m0_addra,
    input  logic [LEN_DATA-1:0]   m0_dina,
    input  logic                  m0_ena,
    input  logic [LEN_DATA/8-1:0] m0_wea,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [LEN_DATA-1:0]   m0_douta,
    input  logic [LEN_ADDR-1:0]   m1_addra,
    input  logic [LEN_DATA-1:0]   m1_dina,
    input  logic                  m1_ena,
    input  logic [LEN_DATA/8-1:0] m1_wea,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [LEN_DATA-1:0]   m1_douta,
    output logic [LEN_ADDR-1:0]   s_addra,
    output logic [LEN_DATA-1:0]   s_dina,
    output logic                  s_ena,
    output logic [LEN_DATA/8-1:0] s_wea,
    input  logic [LEN_DATA-1:0]   s_douta,
    output logic                  lock_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    localparam int              CNT_W   = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             TO_EN   = 1'(LOCK_TIMEOUT > 0);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             rr_last_r;
    logic             resp_valid_r;
    logic             resp_owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             timeout_s;
    logic             own_lock_s;
    logic             own_gnt_s;

    assign own_lock_s = (state_r == ST_LOCK1) ? m1_lock : m0_lock;
    assign own_gnt_s  = gnt0_s | gnt1_s;

    // Grant selection: rr_last_r=1 means master 1 won last, so master 0 takes the tie
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_ena && m1_ena) begin
                        gnt0_s = rr_last_r;
                        gnt1_s = ~rr_last_r;
                    end else begin
                        gnt0_s = m0_ena;
                        gnt1_s = m1_ena;
                    end
                end
                ST_LOCK0: gnt0_s = m0_ena;
                ST_LOCK1: gnt1_s = m1_ena;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Lock state and idle-owner timeout; a release only affects arbitration from the next cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                if (gnt0_s && m0_lock) begin
                    state_nxt_s = ST_LOCK0;
                end else if (gnt1_s && m1_lock) begin
                    state_nxt_s = ST_LOCK1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (own_gnt_s) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = own_lock_s ? state_r : ST_IDLE;
                end else if (!own_lock_s) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else if (!TO_EN) begin
                    cnt_nxt_s   = cnt_r;
                    state_nxt_s = state_r;
                end else if (cnt_r == CNT_MAX) begin
                    timeout_s   = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    state_nxt_s = state_r;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Slave port steering; idle cycles keep master 0 on the address/data lines
    always_comb begin
        s_addra = m0_addra;
        s_dina  = m0_dina;
        s_ena   = 1'b0;
        s_wea   = '0;
        if (gnt1_s) begin
            s_addra = m1_addra;
            s_dina  = m1_dina;
            s_ena   = 1'b1;
            s_wea   = m1_wea;
        end else if (gnt0_s) begin
            s_ena   = 1'b1;
            s_wea   = m0_wea;
        end else begin
            s_ena   = 1'b0;
            s_wea   = '0;
        end
    end

    // State, round-robin pointer, timeout counter and response tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_last_r    <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_owner_r <= 1'b0;
            cnt_r        <= '0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            resp_valid_r <= own_gnt_s;
            resp_owner_r <= gnt1_s;
            if (own_gnt_s) begin
                rr_last_r <= gnt1_s;
            end
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = resp_valid_r & ~resp_owner_r;
    assign m1_rvalid = resp_valid_r & resp_owner_r;
    assign m0_douta  = s_douta;
    assign m1_douta  = s_douta;
    assign lock_err  = timeout_s;

endmodule
